// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART blocks: CPU op encodings, the word returned
// by a read from an empty receive buffer, and the default receive depth.
// Imported by uart_rx_fifo and by the UART transmitter/receiver.
// ---------------------------------------------------------------------------
package uart_pkg;

    // CPU-side UART operation encodings carried on UARTOp
    localparam logic [1:0] UART_OP_IDLE  = 2'b00;
    localparam logic [1:0] UART_OP_READ  = 2'b01;
    localparam logic [1:0] UART_OP_WRITE = 2'b10;

    // Word a load sees when it pops an empty receive buffer
    localparam logic [31:0] EMPTY_WORD = 32'hFFFF_FFFF;

    // Default receive buffer depth in bytes (power of two, >= 2)
    localparam int unsigned UART_RX_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer between the UART receiver and the CPU load path. Each byte
// strobed by the receiver is stored in a circular DEPTH x 8 buffer; a CPU
// read op pops the oldest byte, returned one cycle later on ReadData.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   push         one-cycle "byte received" strobe from the UART receiver
//   push_data    received byte, sampled when push=1
//   UARTOp       CPU UART op; UART_OP_READ pops one byte
//   clr_overrun  one-cycle strobe clearing the sticky overrun flag
//   ReadData     registered pop result: {24'b0, byte} or EMPTY_WORD
//   pop_valid    one-cycle pulse, ReadData holds a real byte
//   count        number of stored bytes, 0..DEPTH
//   empty        count == 0
//   full         count == DEPTH
//   overrun      sticky: a byte was dropped because the buffer was full
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = UART_RX_FIFO_DEPTH,
    parameter int unsigned AW         = $clog2(DEPTH),
    parameter logic [31:0] EMPTY_WORD = uart_pkg::EMPTY_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic [1:0]  UARTOp,
    input  logic        clr_overrun,
    output logic [31:0] ReadData,
    output logic        pop_valid,
    output logic [AW:0] count,
    output logic        empty,
    output logic        full,
    output logic        overrun
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage and bookkeeping registers
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_read_data;
    logic          r_pop_valid;
    logic          r_overrun;

    // Decoded handshake conditions for this edge
    logic w_empty;
    logic w_full;
    logic w_pop_req;
    logic w_pop_acc;
    logic w_push_acc;
    logic w_push_drop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_COUNT);
    assign w_pop_req = (UARTOp == UART_OP_READ);
    assign w_pop_acc = w_pop_req && !w_empty;

    // A pop in the same cycle frees a slot, so a full buffer still accepts
    assign w_push_acc  = push && (!w_full || w_pop_acc);
    assign w_push_drop = push && w_full && !w_pop_acc;

    // Byte array: no reset so synthesis can map it onto distributed RAM
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: push+pop together leaves the count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Pop result: read of the old entry, so a same-cycle push is never bypassed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_read_data <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_acc;
            if (w_pop_acc) begin
                r_read_data <= {24'h0, r_mem[r_rd_ptr]};
            end else if (w_pop_req) begin
                r_read_data <= EMPTY_WORD;
            end
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_push_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign ReadData  = r_read_data;
    assign pop_valid = r_pop_valid;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overrun   = r_overrun;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. A queue-based model tracks stored
// bytes, the last returned word and the overrun flag; each scenario task
// drives stimulus through step() and compares the DUT against the model.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [7:0]  push_data;
    logic [1:0]  UARTOp;
    logic        clr_overrun;
    logic [31:0] ReadData;
    logic        pop_valid;
    logic [AW:0] count;
    logic        empty;
    logic        full;
    logic        overrun;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .UARTOp     (UARTOp),
        .clr_overrun(clr_overrun),
        .ReadData   (ReadData),
        .pop_valid  (pop_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overrun    (overrun)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  q[$];
    logic [31:0] exp_rd;
    logic        exp_pv;
    logic        exp_ovr;

    // One clock of stimulus; the model applies pop-then-push semantics
    task automatic step(input logic p, input logic [7:0] d,
                        input logic [1:0] op, input logic clr);
        logic dropped;
        push        = p;
        push_data   = d;
        UARTOp      = op;
        clr_overrun = clr;
        dropped     = 1'b0;
        exp_pv      = 1'b0;
        if (op == 2'b01) begin
            if (q.size() > 0) begin
                exp_rd = {24'h0, q.pop_front()};
                exp_pv = 1'b1;
            end else begin
                exp_rd = 32'hFFFF_FFFF;
            end
        end
        if (p) begin
            if (q.size() < DEPTH) q.push_back(d);
            else dropped = 1'b1;
        end
        if (dropped) exp_ovr = 1'b1;
        else if (clr) exp_ovr = 1'b0;
        @(posedge clk);
        #1;
        push        = 1'b0;
        UARTOp      = 2'b00;
        clr_overrun = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        exp_rd  = 32'h0;
        exp_pv  = 1'b0;
        exp_ovr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        push = 1'b1; push_data = 8'h99; UARTOp = 2'b00; clr_overrun = 1'b0;
        do_reset();
        push = 1'b0;
        checks++;
        if (ReadData !== 32'h0 || pop_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got rd=%h pv=%b want rd=00000000 pv=0", ReadData, pop_valid);
        end
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got cnt=%0d e=%b f=%b o=%b want 0 1 0 0", count, empty, full, overrun);
        end
    endtask

    task automatic test_empty_read();
        step(1'b0, 8'h00, 2'b01, 1'b0);
        checks++;
        if (ReadData !== 32'hFFFF_FFFF || pop_valid !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin
            failures++;
            $display("FAIL empty_read got rd=%h pv=%b e=%b cnt=%0d want ffffffff 0 1 0",
                     ReadData, pop_valid, empty, count);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'h41 + i), 2'b00, 1'b0);
            checks++;
            if (count !== 5'(i + 1)) begin
                failures++;
                $display("FAIL basic_count got %0d want %0d", count, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 2'b01, 1'b0);
            checks++;
            if (ReadData !== 32'(8'h41 + i) || pop_valid !== 1'b1 || count !== 5'(2 - i)) begin
                failures++;
                $display("FAIL basic_pop got rd=%h pv=%b cnt=%0d want rd=%h pv=1 cnt=%0d",
                         ReadData, pop_valid, count, 32'(8'h41 + i), 2 - i);
            end
        end
        step(1'b0, 8'h00, 2'b00, 1'b0);
        checks++;
        if (ReadData !== 32'h43 || pop_valid !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL basic_hold got rd=%h pv=%b e=%b want 00000043 0 1", ReadData, pop_valid, empty);
        end
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 2'b00, 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL full_set got f=%b cnt=%0d o=%b want 1 16 0", full, count, overrun);
        end
        step(1'b1, 8'hAA, 2'b00, 1'b0);
        checks++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            failures++;
            $display("FAIL full_drop got o=%b cnt=%0d want 1 16", overrun, count);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 2'b01, 1'b0);
            checks++;
            if (ReadData !== 32'(i) || pop_valid !== 1'b1) begin
                failures++;
                $display("FAIL full_drain got rd=%h pv=%b want %h 1", ReadData, pop_valid, 32'(i));
            end
        end
        step(1'b0, 8'h00, 2'b01, 1'b0);
        checks++;
        if (ReadData !== 32'hFFFF_FFFF || empty !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL full_after got rd=%h e=%b o=%b want ffffffff 1 1", ReadData, empty, overrun);
        end
        step(1'b0, 8'h00, 2'b00, 1'b1);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL full_clr got o=%b want 0", overrun);
        end
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 2'b00, 1'b0);
        step(1'b1, 8'h55, 2'b01, 1'b0);
        checks++;
        if (ReadData !== exp_rd || pop_valid !== 1'b1 || count !== 5'd16 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL fullpp got rd=%h pv=%b cnt=%0d o=%b want rd=%h 1 16 0",
                     ReadData, pop_valid, count, overrun, exp_rd);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 2'b01, 1'b0);
            checks++;
            if (ReadData !== exp_rd || pop_valid !== 1'b1) begin
                failures++;
                $display("FAIL fullpp_drain got rd=%h pv=%b want %h 1", ReadData, pop_valid, exp_rd);
            end
        end
        checks++;
        if (ReadData !== 32'h55 || empty !== 1'b1) begin
            failures++;
            $display("FAIL fullpp_last got rd=%h e=%b want 00000055 1", ReadData, empty);
        end
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        logic [7:0] sent[$];
        logic [7:0] got[$];
        while (popped < 40) begin
            if (pushed < 40 && (q.size() < 3 && !(q.size() > 0 && pushed % 3 == 0 && popped < pushed - 0 && q.size() == 3))) begin
                logic [7:0] b = 8'($urandom_range(0, 255));
                sent.push_back(b);
                pushed++;
                step(1'b1, b, 2'b00, 1'b0);
                if (q.size() == 3 || pushed == 40) begin
                    while (q.size() > 0) begin
                        step(1'b0, 8'h00, 2'b01, 1'b0);
                        got.push_back(ReadData[7:0]);
                        popped++;
                        checks++;
                        if (ReadData !== exp_rd || pop_valid !== 1'b1 || count !== 5'(q.size())) begin
                            failures++;
                            $display("FAIL wrap_pop got rd=%h pv=%b cnt=%0d want rd=%h 1 %0d",
                                     ReadData, pop_valid, count, exp_rd, q.size());
                        end
                    end
                end
            end else begin
                break;
            end
        end
        checks++;
        if (got != sent) begin
            failures++;
            $display("FAIL wrap_order got %0d bytes want %0d in push order", got.size(), sent.size());
        end
        // push and pop together with one entry stored: old byte returned
        step(1'b1, 8'h11, 2'b00, 1'b0);
        step(1'b1, 8'h22, 2'b01, 1'b0);
        checks++;
        if (ReadData !== 32'h11 || count !== 5'd1 || pop_valid !== 1'b1) begin
            failures++;
            $display("FAIL one_pp got rd=%h cnt=%0d pv=%b want 00000011 1 1", ReadData, count, pop_valid);
        end
        step(1'b0, 8'h00, 2'b01, 1'b0);
        checks++;
        if (ReadData !== 32'h22 || empty !== 1'b1) begin
            failures++;
            $display("FAIL one_pp_next got rd=%h e=%b want 00000022 1", ReadData, empty);
        end
    endtask

    task automatic test_overrun_clear();
        for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom_range(0, 255)), 2'b00, 1'b0);
        step(1'b1, 8'hEE, 2'b00, 1'b1);
        checks++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            failures++;
            $display("FAIL ovr_setwins got o=%b cnt=%0d want 1 16", overrun, count);
        end
        step(1'b0, 8'h00, 2'b01, 1'b0);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_pop got o=%b want 1", overrun);
        end
        step(1'b0, 8'h00, 2'b00, 1'b1);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clr got o=%b want 0", overrun);
        end
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 2'b00, 1'b0);
        do_reset();
        checks++;
        if (count !== 5'd0 || ReadData !== 32'h0 || empty !== 1'b1 || pop_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset got cnt=%0d rd=%h e=%b pv=%b want 0 00000000 1 0",
                     count, ReadData, empty, pop_valid);
        end
        step(1'b0, 8'h00, 2'b01, 1'b0);
        checks++;
        if (ReadData !== 32'hFFFF_FFFF || pop_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_pop got rd=%h pv=%b want ffffffff 0", ReadData, pop_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic p;
            logic [1:0] op;
            logic clr;
            p   = ($urandom_range(0, 99) < 55);
            op  = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 15) == 0);
            step(p, 8'($urandom_range(0, 255)), op, clr);
            checks++;
            if (ReadData !== exp_rd || pop_valid !== exp_pv || count !== 5'(q.size()) ||
                empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || overrun !== exp_ovr) begin
                failures++;
                $display("FAIL random[%0d] got rd=%h pv=%b cnt=%0d e=%b f=%b o=%b want rd=%h pv=%b cnt=%0d o=%b",
                         i, ReadData, pop_valid, count, empty, full, overrun,
                         exp_rd, exp_pv, q.size(), exp_ovr);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; push_data = 8'h00; UARTOp = 2'b00; clr_overrun = 1'b0;
        exp_rd = 32'h0; exp_pv = 1'b0; exp_ovr = 1'b0;
        #1;
        test_reset();
        test_empty_read();
        test_basic();
        test_full_overrun();
        test_full_pushpop();
        test_wrap();
        test_overrun_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each byte the receiver flags with its one-cycle "byte received" pulse into a circular FIFO.
- Serves bytes to the CPU load path when the CPU issues a UART read op.
- Decouples the asynchronous serial arrival rate from software polling and reports fill level and overrun.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived; do not override).
- EMPTY_WORD, 32'hFFFF_FFFF, value returned on a read from an empty FIFO.

Ports:
- clk  in  1  system clock (100 MHz); all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- push  in  1  one-cycle strobe from the UART receiver: byte valid.
- push_data  in  8  received byte; sampled only when push=1.
- UARTOp  in  2  CPU UART op; 2'b01 = read (pop), others ignored here.
- clr_overrun  in  1  one-cycle strobe that clears the sticky overrun flag.
- ReadData  out  32  registered pop result: {24'b0, byte} or EMPTY_WORD.
- pop_valid  out  1  one-cycle pulse; ReadData holds a real byte this cycle.
- count  out  AW+1  current number of stored bytes, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=0 at a clk edge): rd_ptr, wr_ptr, count = 0; ReadData = 0; pop_valid = 0; overrun = 0; empty = 1; full = 0. Memory contents are not reset.
- Reset mid-operation discards all stored data; no partial state survives.
- Storage: DEPTH x 8 array. wr_ptr and rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0.
- Push accepted: push=1 and (!full or pop accepted in the same cycle). mem[wr_ptr] <= push_data; wr_ptr++.
- Push dropped: push=1, full=1, no pop accepted. Data is discarded, pointers unchanged, overrun <= 1 next cycle.
- Pop accepted: UARTOp==2'b01 and !empty (count before this edge).
  - Next cycle: ReadData = {24'b0, mem[rd_ptr]}, pop_valid = 1, rd_ptr++.
  - Latency is exactly 1 cycle from op to data.
- Pop on empty: next cycle ReadData = EMPTY_WORD, pop_valid = 0, pointers unchanged.
  - No bypass: a push in the same cycle is stored, not returned.
- Hold: when no pop is issued, ReadData keeps its last value and pop_valid = 0.
- Pop held for multiple cycles: each cycle is a separate pop. The CPU path must present a one-cycle op per load.
- count update per edge: +1 on push-only, -1 on pop-only, unchanged on push+pop or neither. empty and full are decoded combinationally from count.
- Simultaneous push and pop when full: both accepted, count stays DEPTH, no overrun.
- Simultaneous push and pop when count==1: both accepted, count stays 1. The popped byte is the old entry.
- Overrun flag:
  - Set on any dropped push.
  - Cleared by clr_overrun.
  - If set and clear occur in the same cycle, set wins.
  - Not cleared by pops.
- Byte order: strict FIFO; bytes read out in push order.
- No combinational path from push or UARTOp to ReadData or pop_valid.

Decomposition:
- Shared package uart_pkg holds:
  - UART op encodings: UART_OP_IDLE=2'b00, UART_OP_READ=2'b01, UART_OP_WRITE=2'b10.
  - EMPTY_WORD constant.
  - Default FIFO depth.
- uart_rx_fifo and the UART transmitter/receiver both import uart_pkg.
- No sub-module required. The pointer/count logic and the DEPTH x 8 register array are local to this block. The array is written so synthesis may infer distributed RAM.

Test Plan:
- Reset, then read with UARTOp=01 on an empty FIFO -> next cycle ReadData=32'hFFFF_FFFF, pop_valid=0, empty=1, count=0.
- Push 8'h41, 8'h42, 8'h43 on separate cycles, then three reads -> ReadData 32'h41, 32'h42, 32'h43 each one cycle after its op, pop_valid=1 each time, count 3->0, empty=1 at the end.
- Push 16 bytes 8'h00..8'h0F (DEPTH=16) -> full=1, count=16. 17th push 8'hAA -> overrun=1, count=16. Drain -> 8'h00..8'h0F; 8'hAA never appears.
- Full FIFO, push 8'h55 and pop in the same cycle -> pop returns the oldest byte, count stays 16, overrun stays 0. Draining then ends with 8'h55.
- Push/pop 40 bytes with count oscillating between 0 and 3 -> pointer wrap is exercised twice and output order matches input order exactly.
- overrun=1, then clr_overrun and a dropped push in the same cycle -> overrun stays 1. Next cycle clr_overrun alone -> overrun=0. Then rst_n=0 mid-fill -> count=0, ReadData=0 next cycle.
